// File: rtl/led_arbiter.sv
// led_arbiter: shares the board LED bank between NUM_REQ on-chip requesters.
// Each accepted request is shown for HOLD_CYCLES clocks; when nothing is being
// shown the LEDs mirror the switch bank with one cycle of latency.
//
// Handshake: a transfer happens in any cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, one-hot, and only
// raised for the round-robin winner while the accept window is open. A
// requester holds valid and data stable until it sees ready; dropping valid
// earlier withdraws the request.
module led_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int LED_W       = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                       clk_100_in,
  input  logic                       rst_in,
  input  logic [LED_W-1:0]           sw,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LED_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [LED_W-1:0]           led,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              busy_q, busy_d;

  logic [LED_W-1:0]  data_arr [NUM_REQ];
  logic              accept_ok;
  logic              found;
  logic [IW-1:0]     winner;
  logic              take;
  int                rr_idx;

  // Split the flat request data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*LED_W +: LED_W];
    end
  end

  // Round-robin search: first valid index after last, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && req_valid[IW'(rr_idx)]) begin
        found  = 1'b1;
        winner = IW'(rr_idx);
      end
    end
  end

  // Accept window: always in IDLE, in SHOW only on the final hold cycle so
  // back-to-back grants follow without a switch-mirror gap. Closed in reset.
  always_comb begin
    accept_ok = !rst_in && ((state_q == IDLE) || (count_q == '0));
    take      = accept_ok && found;
    req_ready = '0;
    if (take) req_ready[winner] = 1'b1;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    grant_d = grant_q;
    led_d   = led_q;
    busy_d  = busy_q;
    if (take) begin
      led_d   = data_arr[winner];
      grant_d = winner;
      last_d  = winner;
      busy_d  = 1'b1;
      count_d = HOLD_LOAD;
      state_d = SHOW;
    end else begin
      case (state_q)
        IDLE: begin
          led_d = sw;
        end
        SHOW: begin
          if (count_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            led_d   = sw;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_100_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter (NUM_REQ=3, LED_W=8, HOLD_CYCLES=4), plus a
// second instance with HOLD_CYCLES=1 for the single-cycle hold case.
module tb_led_arbiter;

  localparam int NUM_REQ = 3;
  localparam int LED_W   = 8;

  typedef struct {
    logic        rst;
    logic [7:0]  sw;
    logic [2:0]  v;
    logic [23:0] data;
    logic [2:0]  ready;
    logic [7:0]  led;
    logic        busy;
    logic [1:0]  grant;
  } vec_t;

  logic        clk_100_in = 1'b0;
  logic        rst_in;
  logic [7:0]  sw;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready, req_ready1;
  logic [7:0]  led, led1;
  logic        busy, busy1;
  logic [1:0]  grant_id, grant_id1;
  logic        state_dbg, state_dbg1;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  // Clock and watchdog.
  always #5 clk_100_in = ~clk_100_in;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  led_arbiter #(.NUM_REQ(NUM_REQ), .LED_W(LED_W), .HOLD_CYCLES(4)) u_dut (
    .clk_100_in(clk_100_in), .rst_in(rst_in), .sw(sw),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .led(led), .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
  );

  led_arbiter #(.NUM_REQ(NUM_REQ), .LED_W(LED_W), .HOLD_CYCLES(1)) u_dut1 (
    .clk_100_in(clk_100_in), .rst_in(rst_in), .sw(sw),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready1),
    .led(led1), .busy(busy1), .grant_id(grant_id1), .state_dbg(state_dbg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied 1 time unit after the rising edge; outputs are read
  // 1 time unit later, still well away from the next edge.
  task automatic apply(input logic r, input logic [7:0] s, input logic [2:0] v, input logic [23:0] d);
    rst_in    = r;
    sw        = s;
    req_valid = v;
    req_data  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_100_in);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] s, input logic [2:0] v, input logic [23:0] d,
                     input logic [2:0] rdy, input logic [7:0] l, input logic b, input logic [1:0] g);
    vec_t t;
    t.rst = r; t.sw = s; t.v = v; t.data = d;
    t.ready = rdy; t.led = l; t.busy = b; t.grant = g;
    vq.push_back(t);
  endtask

  task automatic chk_main(input string tag, input logic [2:0] rdy, input logic [7:0] l,
                          input logic b, input logic [1:0] g);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".led"},       32'(led),       32'(l));
    chk({tag, ".busy"},      32'(busy),      32'(b));
    chk({tag, ".grant_id"},  32'(grant_id),  32'(g));
  endtask

  task automatic chk_h1(input string tag, input logic [2:0] rdy, input logic [7:0] l,
                        input logic b, input logic [1:0] g);
    chk({tag, ".req_ready"}, 32'(req_ready1), 32'(rdy));
    chk({tag, ".led"},       32'(led1),       32'(l));
    chk({tag, ".busy"},      32'(busy1),      32'(b));
    chk({tag, ".grant_id"},  32'(grant_id1),  32'(g));
  endtask

  localparam logic [23:0] D_T2 = 24'h003C00;
  localparam logic [23:0] D_RR = 24'h040201;

  initial begin
    // Expected outputs in each row are the values visible during that cycle.
    // Reset, then idle mirroring of the switches.
    add(1, 8'hA5, 3'b000, 24'h0,  3'b000, 8'h00, 0, 0);
    add(1, 8'hA5, 3'b000, 24'h0,  3'b000, 8'h00, 0, 0);
    add(0, 8'hA5, 3'b000, 24'h0,  3'b000, 8'h00, 0, 0);
    add(0, 8'hA5, 3'b000, 24'h0,  3'b000, 8'hA5, 0, 0);
    // Single grant to requester 1, shown for 4 cycles.
    add(0, 8'hA5, 3'b010, D_T2,   3'b010, 8'hA5, 0, 0);
    add(0, 8'hA5, 3'b000, D_T2,   3'b000, 8'h3C, 1, 1);
    add(0, 8'hA5, 3'b000, D_T2,   3'b000, 8'h3C, 1, 1);
    add(0, 8'hA5, 3'b000, D_T2,   3'b000, 8'h3C, 1, 1);
    add(0, 8'hA5, 3'b000, D_T2,   3'b000, 8'h3C, 1, 1);
    add(0, 8'h5A, 3'b000, 24'h0,  3'b000, 8'hA5, 0, 1);
    add(0, 8'h5A, 3'b000, 24'h0,  3'b000, 8'h5A, 0, 1);
    // Round-robin contention from reset: grants 0,1,2,0 with no gap.
    add(1, 8'h5A, 3'b111, D_RR,   3'b000, 8'h5A, 0, 1);
    add(0, 8'h5A, 3'b111, D_RR,   3'b001, 8'h00, 0, 0);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b111, D_RR,   3'b010, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h02, 1, 1);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h02, 1, 1);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h02, 1, 1);
    add(0, 8'h5A, 3'b111, D_RR,   3'b100, 8'h02, 1, 1);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b111, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b111, D_RR,   3'b001, 8'h04, 1, 2);
    // Requester 2 raises valid mid-SHOW of requester 0; accepted only at count 0.
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b100, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b100, D_RR,   3'b000, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b100, D_RR,   3'b100, 8'h01, 1, 0);
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h04, 1, 2);
    add(0, 8'h5A, 3'b000, D_RR,   3'b000, 8'h5A, 0, 2);

    // First edge applies reset.
    apply(1, 8'h00, 3'b000, 24'h0);
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].sw, vq[i].v, vq[i].data);
      chk_main($sformatf("vec%0d", i), vq[i].ready, vq[i].led, vq[i].busy, vq[i].grant);
      tick();
    end

    // Withdrawal: requester 1 drops valid before the hold ends.
    apply(0, 8'h5A, 3'b001, 24'h000011); chk_main("wd0", 3'b001, 8'h5A, 0, 2); tick();
    apply(0, 8'h5A, 3'b010, 24'h002200); chk_main("wd1", 3'b000, 8'h11, 1, 0);
    chk("wd1.state", 32'(state_dbg), 32'd1); tick();
    apply(0, 8'h5A, 3'b010, 24'h002200); chk_main("wd2", 3'b000, 8'h11, 1, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h002200); chk_main("wd3", 3'b000, 8'h11, 1, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h002200); chk_main("wd4", 3'b000, 8'h11, 1, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h000000); chk_main("wd5", 3'b000, 8'h5A, 0, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h000000); chk_main("wd6", 3'b000, 8'h5A, 0, 0);
    chk("wd6.state", 32'(state_dbg), 32'd0); tick();

    // Reset on the 2nd SHOW cycle while requester 0 is still valid.
    apply(0, 8'h5A, 3'b001, 24'h000077); chk_main("rs0", 3'b001, 8'h5A, 0, 0); tick();
    apply(0, 8'h5A, 3'b001, 24'h000077); chk_main("rs1", 3'b000, 8'h77, 1, 0); tick();
    apply(1, 8'h5A, 3'b001, 24'h000077); chk_main("rs2", 3'b000, 8'h77, 1, 0); tick();
    apply(1, 8'h5A, 3'b001, 24'h000077); chk_main("rs3", 3'b000, 8'h00, 0, 0); tick();
    apply(0, 8'h5A, 3'b011, 24'h008877); chk_main("rs4", 3'b001, 8'h00, 0, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h008877); chk_main("rs5", 3'b000, 8'h77, 1, 0); tick();

    // HOLD_CYCLES=1 instance: a new grant every cycle.
    apply(1, 8'h5A, 3'b000, 24'h008877); tick();
    apply(0, 8'h5A, 3'b011, 24'h008877); chk_h1("h1a", 3'b001, 8'h00, 0, 0); tick();
    apply(0, 8'h5A, 3'b011, 24'h008877); chk_h1("h1b", 3'b010, 8'h77, 1, 0); tick();
    apply(0, 8'h5A, 3'b011, 24'h008877); chk_h1("h1c", 3'b001, 8'h88, 1, 1); tick();
    apply(0, 8'h5A, 3'b000, 24'h008877); chk_h1("h1d", 3'b000, 8'h77, 1, 0); tick();
    apply(0, 8'h5A, 3'b000, 24'h008877); chk_h1("h1e", 3'b000, 8'h5A, 0, 0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
